// File: rtl/load_wide.sv
// Collects NUM_BEATS 64-bit beats from rs1/rs2 and replays them as register-file
// double-writes, with optional per-word byte reversal and reversed drain order.
//
// state | meaning
// IDLE  | waiting for the first beat of a transaction
// FILL  | collecting beats 1..NUM_BEATS-1
// DRAIN | presenting stored beats as rd1/rd2 double-writes
module load_wide #(
    parameter int NUM_BEATS = 2,
    parameter int WORD_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [1:0]        mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] rs1_i,
    input  logic [WORD_W-1:0] rs2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] rd1_o,
    output logic [WORD_W-1:0] rd2_o,
    output logic              out_last_o,
    output logic              busy_o
);

    localparam int CW = $clog2(NUM_BEATS) + 1;
    localparam int IW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [2*WORD_W-1:0] buf_q [NUM_BEATS];
    logic [2*WORD_W-1:0] buf_d [NUM_BEATS];

    logic                in_hs;
    logic                out_hs;
    logic [CW-1:0]       rd_idx;

    function automatic logic [WORD_W-1:0] byte_rev(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < WORD_W / 8; i++) begin
            r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [2*WORD_W-1:0] pack_beat(input logic rev,
                                                       input logic [WORD_W-1:0] lo,
                                                       input logic [WORD_W-1:0] hi);
        if (rev) return {byte_rev(hi), byte_rev(lo)};
        return {hi, lo};
    endfunction

    assign in_ready_o = (state_q != DRAIN);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        mode_d      = mode_q;
        buf_d       = buf_q;

        if (flush_i) begin
            state_d     = IDLE;
            fill_cnt_d  = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        mode_d      = mode_i;
                        buf_d[0]    = pack_beat(mode_i[0], rs1_i, rs2_i);
                        drain_cnt_d = '0;
                        if (NUM_BEATS == 1) begin
                            state_d    = DRAIN;
                            fill_cnt_d = '0;
                        end else begin
                            state_d    = FILL;
                            fill_cnt_d = CW'(1);
                        end
                    end
                end
                FILL: begin
                    if (in_hs) begin
                        buf_d[fill_cnt_q[IW-1:0]] = pack_beat(mode_q[0], rs1_i, rs2_i);
                        if (fill_cnt_q == LAST_IDX) begin
                            state_d     = DRAIN;
                            fill_cnt_d  = '0;
                            drain_cnt_d = '0;
                        end else begin
                            fill_cnt_d = fill_cnt_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (drain_cnt_q == LAST_IDX) begin
                            state_d     = IDLE;
                            drain_cnt_d = '0;
                        end else begin
                            drain_cnt_d = drain_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    fill_cnt_d  = '0;
                    drain_cnt_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (drain_cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            mode_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Buffer has no reset; a reset cycle only blocks the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_q <= buf_d;
        end
    end

    assign rd_idx = mode_q[1] ? (LAST_IDX - drain_cnt_q) : drain_cnt_q;

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (out_valid_q) begin
            rd1_o = buf_q[rd_idx[IW-1:0]][2*WORD_W-1:WORD_W];
            rd2_o = buf_q[rd_idx[IW-1:0]][WORD_W-1:0];
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_load_wide.sv
// Directed bench for load_wide: a 2-beat instance driven from a vector table plus
// stall/flush/reset sequences, and a 1-beat instance for the single-beat case.
module tb_load_wide;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
    logic [1:0]  a_mode;
    logic [31:0] a_rs1, a_rs2, a_rd1, a_rd2;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
    logic [1:0]  b_mode;
    logic [31:0] b_rs1, b_rs2, b_rd1, b_rd2;

    load_wide #(.NUM_BEATS(2), .WORD_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .mode_i(a_mode),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .rs1_i(a_rs1), .rs2_i(a_rs2),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .rd1_o(a_rd1), .rd2_o(a_rd2),
        .out_last_o(a_last), .busy_o(a_busy)
    );

    load_wide #(.NUM_BEATS(1), .WORD_W(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .mode_i(b_mode),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .rs1_i(b_rs1), .rs2_i(b_rs2),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .rd1_o(b_rd1), .rd2_o(b_rd2),
        .out_last_o(b_last), .busy_o(b_busy)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] lo0, hi0, lo1, hi1;
        logic [31:0] e_rd1_0, e_rd2_0, e_rd1_1, e_rd2_1;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents two beats back to back; returns 1 time unit after the second accepting edge.
    task automatic a_fill(input logic [1:0] mode, input logic [31:0] lo0, input logic [31:0] hi0,
                          input logic [31:0] lo1, input logic [31:0] hi1);
        a_mode = mode; a_rs1 = lo0; a_rs2 = hi0; a_in_valid = 1'b1;
        @(negedge clk);
        chk("fill0_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_mode = 2'b00; a_rs1 = lo1; a_rs2 = hi1;
        @(negedge clk);
        chk("fill1_in_ready", 64'(a_in_ready), 64'd1);
        chk("fill1_busy", 64'(a_busy), 64'd1);
        chk("fill1_no_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_rs1 = 32'hDEAD_0000; a_rs2 = 32'hDEAD_1111;
    endtask

    task automatic a_drain(input logic [31:0] r1_0, input logic [31:0] r2_0,
                           input logic [31:0] r1_1, input logic [31:0] r2_1);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("drain0_valid", 64'(a_out_valid), 64'd1);
        chk("drain0_data", {a_rd1, a_rd2}, {r1_0, r2_0});
        chk("drain0_last", 64'(a_last), 64'd0);
        chk("drain0_in_ready", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain1_valid", 64'(a_out_valid), 64'd1);
        chk("drain1_data", {a_rd1, a_rd2}, {r1_1, r2_1});
        chk("drain1_last", 64'(a_last), 64'd1);
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 64'(a_out_valid), 64'd0);
        chk("post_last", 64'(a_last), 64'd0);
        chk("post_busy", 64'(a_busy), 64'd0);
        chk("post_in_ready", 64'(a_in_ready), 64'd1);
        chk("post_data_gated", {a_rd1, a_rd2}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                    32'h07060504, 32'h03020100, 32'h0F0E0D0C, 32'h0B0A0908};
        vecs[1] = '{2'b11, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                    32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
        vecs[2] = '{2'b01, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                    32'h04050607, 32'h00010203, 32'h0C0D0E0F, 32'h08090A0B};
        vecs[3] = '{2'b10, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                    32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        vecs[4] = '{2'b00, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                    32'h55667788, 32'h11223344, 32'hDDEEFF00, 32'h99AABBCC};
        vecs[5] = '{2'b01, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                    32'h88776655, 32'h44332211, 32'h00FFEEDD, 32'hCCBBAA99};

        a_flush = 0; a_mode = 0; a_in_valid = 0; a_rs1 = 0; a_rs2 = 0; a_out_ready = 0;
        b_flush = 0; b_mode = 0; b_in_valid = 0; b_rs1 = 0; b_rs2 = 0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_last", 64'(a_last), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_data", {a_rd1, a_rd2}, 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_busy_valid", {b_busy, b_out_valid, b_last}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            a_fill(vecs[i].mode, vecs[i].lo0, vecs[i].hi0, vecs[i].lo1, vecs[i].hi1);
            a_drain(vecs[i].e_rd1_0, vecs[i].e_rd2_0, vecs[i].e_rd1_1, vecs[i].e_rd2_1);
        end

        // Output back-pressure for 3 cycles; a stray input beat must be ignored.
        a_fill(2'b00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        a_in_valid = 1'b1; a_rs1 = 32'hBAD0BAD0; a_rs2 = 32'hBAD1BAD1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", 64'(a_out_valid), 64'd1);
            chk("stall_data", {a_rd1, a_rd2}, {32'h07060504, 32'h03020100});
            chk("stall_last", 64'(a_last), 64'd0);
            chk("stall_in_ready", 64'(a_in_ready), 64'd0);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_drain(32'h07060504, 32'h03020100, 32'h0F0E0D0C, 32'h0B0A0908);

        // Flush in FILL while a second beat is offered.
        a_mode = 2'b00; a_rs1 = 32'h03020100; a_rs2 = 32'h07060504; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_rs1 = 32'hAAAAAAAA; a_rs2 = 32'h55555555; a_flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_busy", 64'(a_busy), 64'd1);
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(a_busy), 64'd0);
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_fill(vecs[1].mode, vecs[1].lo0, vecs[1].hi0, vecs[1].lo1, vecs[1].hi1);
        a_drain(vecs[1].e_rd1_0, vecs[1].e_rd2_0, vecs[1].e_rd1_1, vecs[1].e_rd2_1);

        // Reset in DRAIN with out_valid high.
        a_fill(2'b11, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        @(negedge clk);
        chk("prerst_valid", 64'(a_out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_last", 64'(a_last), 64'd0);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
        chk("midrst_data", {a_rd1, a_rd2}, 64'd0);
        @(posedge clk); #1;
        // Mode is back to 00 after reset, so this must drain in forward order.
        a_fill(vecs[0].mode, vecs[0].lo0, vecs[0].hi0, vecs[0].lo1, vecs[0].hi1);
        a_drain(vecs[0].e_rd1_0, vecs[0].e_rd2_0, vecs[0].e_rd1_1, vecs[0].e_rd2_1);

        // Single-beat instance.
        for (int m = 0; m < 2; m++) begin
            b_mode = (m == 0) ? 2'b00 : 2'b01;
            b_rs1 = 32'hDEADBEEF; b_rs2 = 32'hCAFEF00D; b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0; b_out_ready = 1'b1;
            @(negedge clk);
            chk("nb1_valid", 64'(b_out_valid), 64'd1);
            chk("nb1_last", 64'(b_last), 64'd1);
            chk("nb1_in_ready", 64'(b_in_ready), 64'd0);
            if (m == 0) chk("nb1_data", {b_rd1, b_rd2}, {32'hCAFEF00D, 32'hDEADBEEF});
            else        chk("nb1_data_rev", {b_rd1, b_rd2}, {32'h0DF0FECA, 32'hEFBEADDE});
            @(posedge clk); #1;
            b_out_ready = 1'b0;
            @(negedge clk);
            chk("nb1_post_valid", 64'(b_out_valid), 64'd0);
            chk("nb1_post_busy", 64'(b_busy), 64'd0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
